// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: shares one packet bus among DRVRS first-word-fall-through
// device FIFOs. Each grant pops a packet, then routes it to one device or
// broadcasts it to all devices except the source. Arbitration is sampled per
// grant as fixed priority or round-robin. A grant may burst up to MAX_BURST
// packets. Every output is registered.
module bus_arbiter_rr #(
    parameter int unsigned       DRVRS     = 4,
    parameter int unsigned       PCKG_SZ   = 16,
    parameter int unsigned       ID_W      = 8,
    parameter logic [ID_W-1:0]   BROADCAST = {ID_W{1'b1}},
    parameter int unsigned       MAX_BURST = 2,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode_rr,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]         pop,
    output logic [DRVRS-1:0]         push,
    output logic [PCKG_SZ-1:0]       D_push,
    output logic                     busy,
    output logic                     err_dest,
    output logic [CNT_W-1:0]         pkt_cnt
);

    localparam int unsigned GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_POP     = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;

    logic [1:0]         r_state;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_rr_ptr;
    logic [BW-1:0]      r_burst_cnt;
    logic [DRVRS-1:0]   r_pop;
    logic [DRVRS-1:0]   r_push;
    logic [PCKG_SZ-1:0] r_pkt;
    logic               r_busy;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [PCKG_SZ-1:0] w_slot [DRVRS];
    logic [GW-1:0]      w_scan;
    logic [GW-1:0]      w_arb_grant;
    logic               w_found;
    logic [PCKG_SZ-1:0] w_head;
    logic [ID_W-1:0]    w_dest;
    logic [DRVRS-1:0]   w_route;
    logic               w_burst_more;
    logic [GW-1:0]      w_ptr_next;

    // Unpacked view of the per-device head packets.
    for (genvar gi = 0; gi < DRVRS; gi++) begin : g_slot
        assign w_slot[gi] = D_pop[gi*PCKG_SZ +: PCKG_SZ];
    end

    // Pick the next grant: scan from rr_ptr in round-robin, from 0 in fixed priority.
    always_comb begin
        w_arb_grant = '0;
        w_found     = 1'b0;
        w_scan      = '0;
        for (int unsigned k = 0; k < DRVRS; k++) begin
            w_scan = mode_rr ? GW'((32'(r_rr_ptr) + k) % DRVRS) : GW'(k);
            if (!w_found && pndng[w_scan]) begin
                w_found     = 1'b1;
                w_arb_grant = w_scan;
            end
        end
    end

    // Decode the granted head packet into a push mask; an empty mask means drop.
    always_comb begin
        w_head  = w_slot[r_grant];
        w_dest  = w_head[PCKG_SZ-1 -: ID_W];
        w_route = '0;
        if (w_dest == BROADCAST) begin
            w_route          = '1;
            w_route[r_grant] = 1'b0;
        end else if (32'(w_dest) < DRVRS && w_dest[GW-1:0] != r_grant) begin
            w_route[w_dest[GW-1:0]] = 1'b1;
        end
    end

    // Burst continuation and the round-robin pointer for the next arbitration.
    always_comb begin
        w_burst_more = pndng[r_grant] && (32'(r_burst_cnt) + 32'd1 < MAX_BURST);
        w_ptr_next   = (r_grant == GW'(DRVRS - 1)) ? '0 : r_grant + 1'b1;
    end

    // Control FSM; pop/push/err are single-cycle strobes, busy mirrors non-IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_pop       <= '0;
            r_push      <= '0;
            r_pkt       <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|pndng) begin
                        r_grant     <= w_arb_grant;
                        r_burst_cnt <= '0;
                        r_pop       <= DRVRS'(1) << w_arb_grant;
                        r_busy      <= 1'b1;
                        r_state     <= S_POP;
                    end
                end
                S_POP: begin
                    r_pkt  <= w_head;
                    r_push <= w_route;
                    r_err  <= ~|w_route;
                    if (|w_route && r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_state <= S_DELIVER;
                end
                S_DELIVER: begin
                    r_pkt       <= '0;
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                    if (w_burst_more) begin
                        r_pop   <= DRVRS'(1) << r_grant;
                        r_state <= S_POP;
                    end else begin
                        r_rr_ptr <= w_ptr_next;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign D_push   = r_pkt;
    assign busy     = r_busy;
    assign err_dest = r_err;
    assign pkt_cnt  = r_cnt;

endmodule
